// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, R/W constant and default word width for the SPI controller
package spi_pkg;
    localparam int WIDTH_DEF = 8;
    localparam logic RW_READ = 1'b1;
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GET_ADDR   = 3'd1,
        LATCH_ADDR = 3'd2,
        READ_LOAD  = 3'd3,
        READ_SEND  = 3'd4,
        WRITE_GET  = 3'd5,
        WRITE_MEM  = 3'd6,
        DONE       = 3'd7
    } state_t;
endpackage

// File: rtl/spi_fsm_if.sv
// spi_fsm_if: handshake bundle between conditioner/shift register and spi_fsm; abort exists under SPI_FSM_ABORT_EN
interface spi_fsm_if #(parameter int WIDTH = spi_pkg::WIDTH_DEF);
    logic             csN;
    logic             sclkRise;
    logic [WIDTH-1:0] shiftRegOut;
    logic             srWe;
    logic             addrWe;
    logic             dmWe;
    logic             misoBufe;
    logic             busy;
`ifdef SPI_FSM_ABORT_EN
    logic             abort;
    modport master(output csN, sclkRise, shiftRegOut, input srWe, addrWe, dmWe, misoBufe, busy, abort);
    modport slave(input csN, sclkRise, shiftRegOut, output srWe, addrWe, dmWe, misoBufe, busy, abort);
`else
    modport master(output csN, sclkRise, shiftRegOut, input srWe, addrWe, dmWe, misoBufe, busy);
    modport slave(input csN, sclkRise, shiftRegOut, output srWe, addrWe, dmWe, misoBufe, busy);
`endif
endinterface

// File: rtl/spi_bitcnt.sv
// spi_bitcnt: saturating bit counter with synchronous clear and increment-on-strobe
module spi_bitcnt #(
    parameter int MAX = 7,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rstN)
        if (!rstN)                          cnt <= '0;
        else if (clr)                       cnt <= '0;
        else if (inc && cnt != W'(MAX))     cnt <= cnt + 1'b1;
endmodule

// File: rtl/spi_fsm.sv
// spi_fsm: single-byte SPI read/write transaction controller with Moore strobes
// Build option SPI_FSM_ABORT_EN adds a one-clk abort pulse when csN rises mid-transaction.
module spi_fsm
    import spi_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input logic     clk,
    input logic     rstN,
    spi_fsm_if.slave bus
);
    state_t            state, nxt;
    logic [CNT_W-1:0]  count;
    logic              counting, last;

    assign counting = state inside {GET_ADDR, READ_SEND, WRITE_GET};
    assign last     = bus.sclkRise && count == CNT_W'(WIDTH - 1);

    spi_bitcnt #(.MAX(WIDTH - 1), .W(CNT_W)) u_bitcnt (
        .clk (clk),
        .rstN(rstN),
        .clr (bus.csN || !counting || last),
        .inc (counting && bus.sclkRise),
        .cnt (count)
    );

    always_ff @(posedge clk or negedge rstN)
        if (!rstN) state <= IDLE;
        else       state <= nxt;

    // csN high overrides every other transition
    always_comb begin
        nxt = state;
        case (state)
            IDLE:       nxt = GET_ADDR;
            GET_ADDR:   nxt = last ? LATCH_ADDR : GET_ADDR;
            LATCH_ADDR: nxt = bus.shiftRegOut[0] == RW_READ ? READ_LOAD : WRITE_GET;
            READ_LOAD:  nxt = READ_SEND;
            READ_SEND:  nxt = last ? DONE : READ_SEND;
            WRITE_GET:  nxt = last ? WRITE_MEM : WRITE_GET;
            WRITE_MEM:  nxt = DONE;
            default:    nxt = state;
        endcase
        if (bus.csN) nxt = IDLE;
    end

    assign bus.addrWe   = state == LATCH_ADDR;
    assign bus.srWe     = state == READ_LOAD;
    assign bus.misoBufe = state == READ_SEND;
    assign bus.dmWe     = state == WRITE_MEM;
    assign bus.busy     = state != IDLE;

`ifdef SPI_FSM_ABORT_EN
    logic abort_q;
    always_ff @(posedge clk or negedge rstN)
        if (!rstN) abort_q <= 1'b0;
        else       abort_q <= bus.csN && state inside {GET_ADDR, LATCH_ADDR, READ_LOAD, READ_SEND, WRITE_GET};
    assign bus.abort = abort_q;
`endif
endmodule

// File: tb/tb_spi_fsm.sv
// tb_spi_fsm: randomized self-checking bench; model tracks counted SCLK edges and their timestamps
module tb_spi_fsm;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    spi_fsm_if #(.WIDTH(8)) bus();
    spi_fsm #(.WIDTH(8)) dut(.clk(clk), .rstN(rstN), .bus(bus));

    int checks = 0, failures = 0;
    bit active, rd, exp_abort;
    int n, k, e8, e16;
    logic [7:0] sr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        active = 0; n = 0; e8 = -100; e16 = -100; exp_abort = 0;
    endtask

    task automatic check_outputs();
        check("busy", bus.busy, active);
        check("addrWe", bus.addrWe, active && k == e8);
        check("srWe", bus.srWe, active && rd && e8 >= 0 && k == e8 + 1);
        check("misoBufe", bus.misoBufe, active && rd && e8 >= 0 && k >= e8 + 2 && (e16 < 0 || k < e16));
        check("dmWe", bus.dmWe, active && !rd && e16 >= 0 && k == e16);
`ifdef SPI_FSM_ABORT_EN
        check("abort", bus.abort, exp_abort);
`endif
    endtask

    // one clk: drive at negedge, update model at posedge, compare at next negedge
    task automatic step(input bit cs, input bit rise, input bit mosi);
        bus.csN = cs;
        bus.sclkRise = rise;
        @(posedge clk);
        k++;
        if (cs) begin
            exp_abort = active && n < 16;
            active = 0; n = 0; e8 = -100; e16 = -100;
        end else if (!active) begin
            active = 1; n = 0; exp_abort = 0;
        end else begin
            exp_abort = 0;
            if (rise && n < 16) begin
                n++;
                if (n == 8) e8 = k;
                if (n == 16) e16 = k;
            end
        end
        #1;
        if (rise) sr = {sr[6:0], mosi};
        bus.shiftRegOut = sr;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic txn(input logic [7:0] b, input int stop_at, input bit entry_edge);
        logic [15:0] bits;
        bits = {b, 8'($urandom)};
        rd = b[0];
        step(0, entry_edge, 1'b0);
        for (int i = 0; i < 16 && i != stop_at; i++) begin
            repeat ($urandom_range(2, 4)) step(0, 0, 0);
            step(0, 1, bits[15-i]);
        end
        repeat ($urandom_range(0, 4)) step(0, 0, 0);
        if (stop_at < 0 && $urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(2, 4)) step(0, 0, 0);
            step(0, 1, 1'b1);
        end
        step(1, 0, 0);
        step(1, 0, 0);
    endtask

    task automatic reset_mid_read();
        logic [15:0] bits;
        bits = {8'hA5, 8'h3C};
        rd = 1;
        step(0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            repeat (2) step(0, 0, 0);
            step(0, 1, bits[15-i]);
        end
        step(0, 0, 0);
        check("pre_rst_miso", bus.misoBufe, 1);
        #2 rstN = 1'b0;
        #1;
        model_reset();
        check("rst_busy", bus.busy, 0);
        check("rst_miso", bus.misoBufe, 0);
        check("rst_strobes", {bus.addrWe, bus.srWe, bus.dmWe}, 0);
        @(negedge clk);
        rstN = 1'b1;
        step(1, 0, 0);
        step(1, 0, 0);
    endtask

    initial begin
        bus.csN = 1'b1;
        bus.sclkRise = 1'b0;
        bus.shiftRegOut = '0;
        sr = '0;
        k = 0;
        rd = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rstN = 1'b1;
        step(1, 0, 0);
        txn(8'hA4, -1, 0);
        txn(8'hA5, -1, 0);
        txn(8'hA4, 5, 0);
        txn(8'hA5, 5, 0);
        txn({7'h11, 1'b0}, -1, 0);
        txn({7'h11, 1'b1}, -1, 0);
        txn(8'hA4, -1, 1);
        txn(8'hA5, 8, 0);
        reset_mid_read();
        for (int t = 0; t < 40; t++)
            txn(8'($urandom), $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 15)) : -1,
                $urandom_range(0, 3) == 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
